// File: rtl/riscv_id_counters.sv
// Machine ID CSRs plus 64-bit mcycle/minstret; RV12_MCOUNTINHIBIT_EN adds mcountinhibit at 0xB20.
// Latency: one cycle from csr_req to csr_ack/csr_err/csr_rdata.
// Backpressure: none; a request may be issued every cycle.
module riscv_id_counters #(
   parameter int          XLEN     = 32,
   parameter int unsigned VENDORID = 0,
   parameter int unsigned HARTID   = 0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            csr_req,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            csr_ack,
   output logic            csr_err,
   output logic [XLEN-1:0] csr_rdata,
   input  logic            instret
);

   localparam int unsigned ARCHID       = 12;
   localparam logic [7:0]  REVPRV_MAJOR = 8'd1;
   localparam logic [7:0]  REVPRV_MINOR = 8'd10;
   localparam logic [7:0]  REVUSR_MAJOR = 8'd2;
   localparam logic [7:0]  REVUSR_MINOR = 8'd2;
   localparam logic [31:0] MIMPID       = {REVPRV_MAJOR, REVPRV_MINOR, REVUSR_MAJOR, REVUSR_MINOR};

   localparam logic [11:0] A_MVENDORID     = 12'hF11;
   localparam logic [11:0] A_MARCHID       = 12'hF12;
   localparam logic [11:0] A_MIMPID        = 12'hF13;
   localparam logic [11:0] A_MHARTID       = 12'hF14;
   localparam logic [11:0] A_MCYCLE        = 12'hB00;
   localparam logic [11:0] A_MINSTRET      = 12'hB02;
   localparam logic [11:0] A_MCYCLEH       = 12'hB80;
   localparam logic [11:0] A_MINSTRETH     = 12'hB82;
`ifdef RV12_MCOUNTINHIBIT_EN
   localparam logic [11:0] A_MCOUNTINHIBIT = 12'hB20;
`endif

   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [63:0]     mcycle_q, mcycle_d;
   logic [63:0]     minstret_q, minstret_d;

   logic            addr_hit;
   logic            addr_ro;
   logic            acc_err;
   logic            wr_ok;
   logic [XLEN-1:0] rd_val;
   logic            cy_inh;
   logic            ir_inh;

`ifdef RV12_MCOUNTINHIBIT_EN
   logic cy_inh_q, cy_inh_d;
   logic ir_inh_q, ir_inh_d;

   assign cy_inh = cy_inh_q;
   assign ir_inh = ir_inh_q;
`else
   assign cy_inh = 1'b0;
   assign ir_inh = 1'b0;
`endif

   // Address decode and read mux; counter reads see the value before this edge's update.
   always_comb begin
      addr_hit = 1'b1;
      addr_ro  = 1'b0;
      rd_val   = '0;
      case (csr_addr)
         A_MVENDORID: begin
            rd_val  = XLEN'(VENDORID);
            addr_ro = 1'b1;
         end
         A_MARCHID: begin
            rd_val  = XLEN'(ARCHID);
            addr_ro = 1'b1;
         end
         A_MIMPID: begin
            rd_val  = XLEN'(MIMPID);
            addr_ro = 1'b1;
         end
         A_MHARTID: begin
            rd_val  = XLEN'(HARTID);
            addr_ro = 1'b1;
         end
         A_MCYCLE:    rd_val = XLEN'(mcycle_q);
         A_MINSTRET:  rd_val = XLEN'(minstret_q);
         A_MCYCLEH: begin
            if (XLEN == 32) rd_val = XLEN'(mcycle_q[63:32]);
            else            addr_hit = 1'b0;
         end
         A_MINSTRETH: begin
            if (XLEN == 32) rd_val = XLEN'(minstret_q[63:32]);
            else            addr_hit = 1'b0;
         end
`ifdef RV12_MCOUNTINHIBIT_EN
         A_MCOUNTINHIBIT: rd_val = XLEN'({29'd0, ir_inh_q, 1'b0, cy_inh_q});
`endif
         default: addr_hit = 1'b0;
      endcase
   end

   assign acc_err = !addr_hit || (csr_we && addr_ro);
   assign wr_ok   = csr_req && csr_we && !acc_err;

   always_comb begin
      ack_d   = csr_req;
      err_d   = csr_req && acc_err;
      rdata_d = (csr_req && !acc_err) ? rd_val : '0;
   end

   // A 64-bit add carries low-to-high in the same cycle; a write replaces the increment outright.
   always_comb begin
      mcycle_d   = mcycle_q + (cy_inh ? 64'd0 : 64'd1);
      minstret_d = minstret_q + ((instret && !ir_inh) ? 64'd1 : 64'd0);
      if (wr_ok) begin
         case (csr_addr)
            A_MCYCLE: begin
               if (XLEN == 64) mcycle_d = 64'(csr_wdata);
               else            mcycle_d = {mcycle_q[63:32], csr_wdata[31:0]};
            end
            A_MINSTRET: begin
               if (XLEN == 64) minstret_d = 64'(csr_wdata);
               else            minstret_d = {minstret_q[63:32], csr_wdata[31:0]};
            end
            A_MCYCLEH:   mcycle_d   = {csr_wdata[31:0], mcycle_q[31:0]};
            A_MINSTRETH: minstret_d = {csr_wdata[31:0], minstret_q[31:0]};
            default: ;
         endcase
      end
   end

`ifdef RV12_MCOUNTINHIBIT_EN
   // New inhibit bits gate increments starting at the edge after the write.
   always_comb begin
      cy_inh_d = cy_inh_q;
      ir_inh_d = ir_inh_q;
      if (wr_ok && csr_addr == A_MCOUNTINHIBIT) begin
         cy_inh_d = csr_wdata[0];
         ir_inh_d = csr_wdata[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cy_inh_q <= 1'b0;
         ir_inh_q <= 1'b0;
      end else begin
         cy_inh_q <= cy_inh_d;
         ir_inh_q <= ir_inh_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   assign csr_ack   = ack_q;
   assign csr_err   = err_q;
   assign csr_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_id_counters.sv
// Self-checking bench for riscv_id_counters against a cycle-level behavioural model.
module tb_riscv_id_counters;

   localparam int          XLEN = 32;
   localparam int unsigned VID  = 32'h0000_0A5B;
   localparam int unsigned HID  = 3;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            csr_req = 1'b0;
   logic            csr_we = 1'b0;
   logic [11:0]     csr_addr = '0;
   logic [XLEN-1:0] csr_wdata = '0;
   logic            instret = 1'b0;
   logic            csr_ack;
   logic            csr_err;
   logic [XLEN-1:0] csr_rdata;

   riscv_id_counters #(.XLEN(XLEN), .VENDORID(VID), .HARTID(HID)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .csr_req   (csr_req),
      .csr_we    (csr_we),
      .csr_addr  (csr_addr),
      .csr_wdata (csr_wdata),
      .csr_ack   (csr_ack),
      .csr_err   (csr_err),
      .csr_rdata (csr_rdata),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   // Model state: full 64-bit counters and the inhibit word.
   logic [63:0]     m_cyc = '0;
   logic [63:0]     m_ins = '0;
   logic [31:0]     m_inh = '0;
   logic            e_ack;
   logic            e_err;
   logic [XLEN-1:0] e_rdata;
   int              n_cmp = 0;
   int              n_bad = 0;

   // Drive one cycle, predict the response seen after the edge, advance the model.
   task automatic step(input logic r, input logic req, input logic we, input logic [11:0] a,
                       input logic [XLEN-1:0] wd, input logic ir);
      logic [63:0] val;
      logic [63:0] nc;
      logic [63:0] ni;
      logic        ok;
      logic        ro;
      rstn = r; csr_req = req; csr_we = we; csr_addr = a; csr_wdata = wd; instret = ir;
      if (!r) begin
         e_ack = 1'b0; e_err = 1'b0; e_rdata = '0;
         m_cyc = '0; m_ins = '0; m_inh = '0;
      end else begin
         ok = 1'b1; ro = 1'b0; val = '0;
         case (a)
            12'hF11: begin val = 64'(VID); ro = 1'b1; end
            12'hF12: begin val = 64'd12; ro = 1'b1; end
            12'hF13: begin val = 64'h010A_0202; ro = 1'b1; end
            12'hF14: begin val = 64'(HID); ro = 1'b1; end
            12'hB00: val = m_cyc;
            12'hB02: val = m_ins;
            12'hB80: if (XLEN == 32) val = m_cyc >> 32; else ok = 1'b0;
            12'hB82: if (XLEN == 32) val = m_ins >> 32; else ok = 1'b0;
`ifdef RV12_MCOUNTINHIBIT_EN
            12'hB20: val = 64'(m_inh);
`endif
            default: ok = 1'b0;
         endcase
         if (we && ro) ok = 1'b0;
         e_ack   = req;
         e_err   = req && !ok;
         e_rdata = (req && ok) ? XLEN'(val) : '0;
         nc = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
         ni = m_ins + ((ir && !m_inh[2]) ? 64'd1 : 64'd0);
         if (req && we && ok) begin
            case (a)
               12'hB00: nc = (XLEN == 64) ? 64'(wd) : ((m_cyc & 64'hFFFF_FFFF_0000_0000) | 64'(wd));
               12'hB02: ni = (XLEN == 64) ? 64'(wd) : ((m_ins & 64'hFFFF_FFFF_0000_0000) | 64'(wd));
               12'hB80: nc = (m_cyc & 64'h0000_0000_FFFF_FFFF) | (64'(wd) << 32);
               12'hB82: ni = (m_ins & 64'h0000_0000_FFFF_FFFF) | (64'(wd) << 32);
               12'hB20: m_inh = 32'(wd) & 32'h5;
               default: ;
            endcase
         end
         m_cyc = nc;
         m_ins = ni;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 12'hB00, '0, 1'b1);
         n_cmp++;
         if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
            n_bad++;
            $display("FAIL reset[%0d]: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                     i, csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
         end
      end
      // First cycle out of reset: counters must read zero.
      step(1'b1, 1'b1, 1'b0, 12'hB00, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
         n_bad++;
         $display("FAIL reset_mcycle: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                  csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
      end
   endtask

   task automatic test_id_regs();
      logic [11:0] addrs [4] = '{12'hF12, 12'hF13, 12'hF14, 12'hF11};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, addrs[i], '0, 1'b0);
         n_cmp++;
         if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
            n_bad++;
            $display("FAIL id_read %h: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                     addrs[i], csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
         end
         step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b0);
         n_cmp++;
         if (csr_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL id_idle_ack: got %0b want 0", csr_ack);
         end
      end
   endtask

   task automatic test_errors();
      logic [11:0] addrs [5] = '{12'hF11, 12'hF11, 12'h7C0, 12'hF14, 12'hB20};
      logic        wes   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, wes[i], addrs[i], XLEN'(32'h55), 1'b0);
         n_cmp++;
         if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
            n_bad++;
            $display("FAIL err_access %h we=%0b: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                     addrs[i], wes[i], csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
         end
      end
   endtask

   task automatic test_carry();
      step(1'b1, 1'b1, 1'b1, 12'hB00, XLEN'(32'hFFFF_FFFE), 1'b0);
      step(1'b1, 1'b1, 1'b1, 12'hB80, '0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 12'hB80, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {1'b1, 1'b0, XLEN'(1)}) begin
         n_bad++;
         $display("FAIL carry_mcycleh: got ack=%0b err=%0b rdata=%h, want 1 0 1",
                  csr_ack, csr_err, csr_rdata);
      end
      step(1'b1, 1'b1, 1'b0, 12'hB00, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
         n_bad++;
         $display("FAIL carry_mcycle: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                  csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
      end
   endtask

   task automatic test_instret();
      step(1'b1, 1'b1, 1'b1, 12'hB02, '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b1);
         step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 12'hB02, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {1'b1, 1'b0, XLEN'(5)}) begin
         n_bad++;
         $display("FAIL instret_count: got ack=%0b err=%0b rdata=%h, want 1 0 5",
                  csr_ack, csr_err, csr_rdata);
      end
      // A pulse coinciding with the write is lost to the write.
      step(1'b1, 1'b1, 1'b1, 12'hB02, XLEN'(100), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 12'hB02, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {1'b1, 1'b0, XLEN'(103)}) begin
         n_bad++;
         $display("FAIL instret_write_wins: got ack=%0b err=%0b rdata=%h, want 1 0 0x67",
                  csr_ack, csr_err, csr_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [4] = '{12'hF12, 12'hF13, 12'hF14, 12'hB00};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, addrs[i], '0, 1'b0);
         n_cmp++;
         if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
            n_bad++;
            $display("FAIL b2b[%0d] %h: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                     i, addrs[i], csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
         end
      end
   endtask

`ifdef RV12_MCOUNTINHIBIT_EN
   task automatic test_inhibit();
      step(1'b1, 1'b1, 1'b1, 12'hB20, XLEN'(5), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b1, 1'b0, 12'hB00, '0, 1'b1);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
         n_bad++;
         $display("FAIL inhibit_mcycle: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                  csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
      end
      step(1'b1, 1'b1, 1'b0, 12'hB02, '0, 1'b1);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
         n_bad++;
         $display("FAIL inhibit_minstret: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                  csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
      end
      step(1'b1, 1'b1, 1'b1, 12'hB20, '1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 12'hB20, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {1'b1, 1'b0, XLEN'(5)}) begin
         n_bad++;
         $display("FAIL inhibit_readback: got ack=%0b err=%0b rdata=%h, want 1 0 5",
                  csr_ack, csr_err, csr_rdata);
      end
      step(1'b1, 1'b1, 1'b1, 12'hB20, '0, 1'b0);
   endtask
`endif

   task automatic test_random();
      logic [11:0] addrs [11] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00, 12'hB02,
                                  12'hB80, 12'hB82, 12'hB20, 12'h7C0, 12'hB01};
      logic        req;
      logic        we;
      logic [11:0] a;
      logic [XLEN-1:0] wd;
      for (int i = 0; i < 400; i++) begin
         req = ($urandom_range(0, 3) != 0);
         we  = ($urandom_range(0, 3) == 0);
         a   = addrs[$urandom_range(0, 10)];
         wd  = XLEN'($urandom);
         if ($urandom_range(0, 3) == 0) wd = XLEN'(32'hFFFF_FFF0 + $urandom_range(0, 15));
         step(($urandom_range(0, 99) != 0), req, we, a, wd, 1'($urandom_range(0, 1)));
         n_cmp++;
         if (csr_ack !== e_ack || (e_ack && {csr_err, csr_rdata} !== {e_err, e_rdata})) begin
            n_bad++;
            $display("FAIL random[%0d] %h we=%0b: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                     i, a, we, csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
         end
      end
   endtask

   task automatic test_reset_inflight();
      step(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 12'hF12, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 12'h000, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_drop_ack: got ack=%0b err=%0b, want 0 0", csr_ack, csr_err);
      end
      step(1'b1, 1'b1, 1'b0, 12'hB00, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {1'b1, 1'b0, XLEN'(0)}) begin
         n_bad++;
         $display("FAIL reset_mcycle_zero: got ack=%0b err=%0b rdata=%h, want 1 0 0",
                  csr_ack, csr_err, csr_rdata);
      end
      step(1'b1, 1'b1, 1'b0, 12'hB02, '0, 1'b0);
      n_cmp++;
      if ({csr_ack, csr_err, csr_rdata} !== {e_ack, e_err, e_rdata}) begin
         n_bad++;
         $display("FAIL reset_minstret_zero: got ack=%0b err=%0b rdata=%h, want %0b %0b %h",
                  csr_ack, csr_err, csr_rdata, e_ack, e_err, e_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_id_regs();
      test_errors();
      test_carry();
      test_instret();
      test_back_to_back();
`ifdef RV12_MCOUNTINHIBIT_EN
      test_inhibit();
`endif
      test_random();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_id_counters.md
Name: riscv_id_counters

Overview:
- Machine-level identification and base-counter CSR unit.
- Sits directly downstream of the RV12 definitions package and consumes its constants: ARCHID feeds marchid; REVPRV_MAJOR, REVPRV_MINOR, REVUSR_MAJOR and REVUSR_MINOR feed mimpid.
- Serves mvendorid, marchid, mimpid and mhartid, and maintains the 64-bit mcycle and minstret counters behind a simple request/acknowledge CSR port driven by the core's CSR stage.

Parameters:
- XLEN, 32, data width; 32 or 64.
- VENDORID, 0, value returned for mvendorid.
- HARTID, 0, value returned for mhartid.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- csr_req  in  1  CSR access request, single-cycle qualifier.
- csr_we  in  1  1 = write, 0 = read; qualified by csr_req.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write data.
- csr_ack  out  1  response valid, exactly one per request.
- csr_err  out  1  illegal access; valid with csr_ack.
- csr_rdata  out  XLEN  read data; valid with csr_ack.
- instret  in  1  one-cycle pulse per retired instruction.

Behaviour:
- Reset: rstn low at a clock edge sets csr_ack=0, csr_err=0, csr_rdata=0, mcycle=0, minstret=0. A request in flight during reset is dropped and no ack is issued.
- Handshake: csr_req sampled at edge N produces csr_ack=1 during cycle N+1, with csr_rdata and csr_err. Latency is fixed at 1. Back-to-back requests every cycle are supported, giving an ack every cycle. No backpressure.
- csr_rdata returns the pre-write value on writes, and 0 on error.
- Address map:
  - 0xF11 mvendorid = VENDORID.
  - 0xF12 marchid = ARCHID (12).
  - 0xF13 mimpid = {REVPRV_MAJOR[7:0], REVPRV_MINOR[7:0], REVUSR_MAJOR[7:0], REVUSR_MINOR[7:0]} = 0x010A0202, zero-extended to XLEN.
  - 0xF14 mhartid = HARTID.
  - 0xB00 mcycle.
  - 0xB02 minstret.
  - 0xB80 mcycleh and 0xB82 minstreth exist only when XLEN=32 and return bits [63:32].
- Errors: csr_err=1 for any write to 0xF11–0xF14, any unmapped address, and 0xB80/0xB82 when XLEN=64. Erroring writes modify no state.
- mcycle: increments by 1 every cycle outside reset, wrapping 0xFFFF_FFFF_FFFF_FFFF → 0.
- minstret: increments by 1 in each cycle where instret=1, with the same wrap.
- XLEN=32 carry: carry from the low word into the high word occurs in the same cycle; the full 64-bit counter updates atomically.
- Counter write at edge N:
  - Addressed half ← csr_wdata. With XLEN=64 the whole counter is written.
  - Non-addressed half holds its value.
  - That counter does not increment at edge N; write wins over increment and over carry.
  - Counting resumes at edge N+1.
- Read/increment ordering: a read at edge N returns the counter value before edge N's update.
- instret with no CSR traffic is never lost.

Optional Feature:
- Macro: RV12_MCOUNTINHIBIT_EN.
- Defined:
  - Adds a 32-bit mcountinhibit register at 0xB20, read/write, reset 0.
  - Only bits 0 (CY) and 2 (IR) are writable; all other bits read 0.
  - CY=1 freezes mcycle; IR=1 freezes minstret.
  - A freeze takes effect for increments at edge N+1 after the write at edge N.
  - Explicit counter writes still apply while inhibited.
- Undefined: 0xB20 is unmapped (csr_err=1) and counters always run.

Test Plan:
- Reset, then read 0xF12 and 0xF13 → ack one cycle later, rdata=12 then 0x010A0202, err=0. Read 0xF14 with HARTID=3 → 3.
- Write 0xF11 data 0x55 → ack, err=1, a later read of 0xF11 still returns VENDORID. Read 0x7C0 → err=1, rdata=0.
- XLEN=32: write mcycle=0xFFFF_FFFE and mcycleh=0, idle 3 cycles, read mcycleh → 1. Then read mcycle → small value consistent with the elapsed cycle count.
- Pulse instret 5 times interleaved with idle cycles, then read minstret → 5. Pulse instret in the same cycle as a write minstret=100 → subsequent read shows 100 plus only the later pulses.
- Issue requests on 4 consecutive cycles → 4 consecutive acks in order. Assert rstn=0 the cycle after a request → no ack, counters=0.
- With RV12_MCOUNTINHIBIT_EN: write 0xB20=0x5, wait 10 cycles with instret pulses → mcycle and minstret unchanged. Read 0xB20 after writing 0xFFFF_FFFF → 0x5. Without the macro, access to 0xB20 → err=1.
